// File: rtl/wb_rr_arbiter.sv
// wb_rr_arbiter: three-master round-robin Wishbone arbiter with per-transaction stall watchdog
module wb_rr_arbiter #(
    parameter int TIMEOUT = 1023
) (
    input  logic        sys_clk,
    input  logic        sys_rst_n,
    input  logic [31:0] m0_adr_i,
    input  logic [31:0] m0_dat_i,
    output logic [31:0] m0_dat_o,
    input  logic [3:0]  m0_sel_i,
    input  logic [2:0]  m0_cti_i,
    input  logic        m0_we_i,
    input  logic        m0_cyc_i,
    input  logic        m0_stb_i,
    output logic        m0_ack_o,
    output logic        m0_err_o,
    input  logic [31:0] m1_adr_i,
    input  logic [31:0] m1_dat_i,
    output logic [31:0] m1_dat_o,
    input  logic [3:0]  m1_sel_i,
    input  logic [2:0]  m1_cti_i,
    input  logic        m1_we_i,
    input  logic        m1_cyc_i,
    input  logic        m1_stb_i,
    output logic        m1_ack_o,
    output logic        m1_err_o,
    input  logic [31:0] m2_adr_i,
    input  logic [31:0] m2_dat_i,
    output logic [31:0] m2_dat_o,
    input  logic [3:0]  m2_sel_i,
    input  logic [2:0]  m2_cti_i,
    input  logic        m2_we_i,
    input  logic        m2_cyc_i,
    input  logic        m2_stb_i,
    output logic        m2_ack_o,
    output logic        m2_err_o,
    output logic [31:0] s_adr_o,
    output logic [31:0] s_dat_o,
    output logic [3:0]  s_sel_o,
    output logic [2:0]  s_cti_o,
    output logic        s_we_o,
    output logic        s_cyc_o,
    output logic        s_stb_o,
    input  logic [31:0] s_dat_i,
    input  logic        s_ack_i,
    input  logic        s_err_i,
    output logic [2:0]  grant_o,
    output logic        timeout_o
);
    typedef enum logic [1:0] {IDLE, BUSY, ABORT} state_t;

    localparam logic [15:0] WD_LAST = 16'(TIMEOUT - 1);

    state_t state, state_nxt;
    logic [1:0] last, pick;
    logic [15:0] wd;
    logic [2:0][31:0] adr, dat;
    logic [2:0][3:0] sel;
    logic [2:0][2:0] cti;
    logic [2:0] we, cyc, stb;
    logic g_cyc, g_stb, busy, abort_now, fire;

    assign adr = {m2_adr_i, m1_adr_i, m0_adr_i};
    assign dat = {m2_dat_i, m1_dat_i, m0_dat_i};
    assign sel = {m2_sel_i, m1_sel_i, m0_sel_i};
    assign cti = {m2_cti_i, m1_cti_i, m0_cti_i};
    assign we  = {m2_we_i, m1_we_i, m0_we_i};
    assign cyc = {m2_cyc_i, m1_cyc_i, m0_cyc_i};
    assign stb = {m2_stb_i, m1_stb_i, m0_stb_i};

    // last always holds the granted index while BUSY or ABORT
    assign g_cyc = cyc[last];
    assign g_stb = stb[last];
    assign busy = state == BUSY;
    assign abort_now = state == ABORT && timeout_o;
    assign fire = TIMEOUT != 0 && busy && g_cyc && g_stb && !s_ack_i && !s_err_i && wd == WD_LAST;

    // round-robin: first requester after the last winner
    always_comb begin
        pick = last == 2'd2 ? (cyc[0] ? 2'd0 : cyc[1] ? 2'd1 : 2'd2) :
               last == 2'd0 ? (cyc[1] ? 2'd1 : cyc[2] ? 2'd2 : 2'd0) :
                              (cyc[2] ? 2'd2 : cyc[0] ? 2'd0 : 2'd1);
    end

    // next state: grant on any request, release when the owner drops cyc, abort on stall
    always_comb begin
        state_nxt = state;
        state_nxt = state == IDLE ? (|cyc ? BUSY : IDLE) : !g_cyc ? IDLE : fire ? ABORT : state;
    end

    // state, grant, rotation pointer and watchdog registers
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state     <= IDLE;
            grant_o   <= 3'b000;
            last      <= 2'd2;
            wd        <= 16'd0;
            timeout_o <= 1'b0;
        end else begin
            state     <= state_nxt;
            grant_o   <= state_nxt == IDLE ? 3'b000 : state == IDLE ? 3'b001 << pick : grant_o;
            last      <= state == IDLE && |cyc ? pick : last;
            wd        <= busy && g_stb && !s_ack_i && !s_err_i ? wd + 16'd1 : 16'd0;
            timeout_o <= fire;
        end
    end

    assign s_adr_o = busy ? adr[last] : 32'd0;
    assign s_dat_o = busy ? dat[last] : 32'd0;
    assign s_sel_o = busy ? sel[last] : 4'd0;
    assign s_cti_o = busy ? cti[last] : 3'd0;
    assign s_we_o  = busy & we[last];
    assign s_cyc_o = busy & g_cyc;
    assign s_stb_o = busy & g_stb;

    assign m0_dat_o = s_dat_i;
    assign m1_dat_o = s_dat_i;
    assign m2_dat_o = s_dat_i;

    assign m0_ack_o = busy & grant_o[0] & s_ack_i;
    assign m1_ack_o = busy & grant_o[1] & s_ack_i;
    assign m2_ack_o = busy & grant_o[2] & s_ack_i;

    assign m0_err_o = grant_o[0] & ((busy & s_err_i) | abort_now);
    assign m1_err_o = grant_o[1] & ((busy & s_err_i) | abort_now);
    assign m2_err_o = grant_o[2] & ((busy & s_err_i) | abort_now);
endmodule

// File: tb/tb_wb_rr_arbiter.sv
// tb_wb_rr_arbiter: directed and randomized checks of wb_rr_arbiter against a transaction-level model
module tb_wb_rr_arbiter;
    logic sys_clk = 1'b0;
    logic sys_rst_n;
    logic [31:0] adr [3];
    logic [31:0] dat [3];
    logic [3:0]  sel [3];
    logic [2:0]  cti [3];
    logic        we  [3];
    logic        cyc [3];
    logic        stb [3];
    logic [31:0] dat_o [3];
    logic [2:0]  ack_o, err_o;
    logic [31:0] s_adr_o, s_dat_o, s_dat_i;
    logic [3:0]  s_sel_o;
    logic [2:0]  s_cti_o, grant_o;
    logic        s_we_o, s_cyc_o, s_stb_o, s_ack_i, s_err, timeout_o;
    logic        ack_mode, ack_drv;
    int n_chk = 0;
    int n_fail = 0;
    int last_m = 2;

    always #5 sys_clk = ~sys_clk;

    assign s_ack_i = ack_mode ? s_stb_o : ack_drv;

    wb_rr_arbiter #(.TIMEOUT(8)) dut (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n),
        .m0_adr_i(adr[0]), .m0_dat_i(dat[0]), .m0_dat_o(dat_o[0]), .m0_sel_i(sel[0]), .m0_cti_i(cti[0]),
        .m0_we_i(we[0]), .m0_cyc_i(cyc[0]), .m0_stb_i(stb[0]), .m0_ack_o(ack_o[0]), .m0_err_o(err_o[0]),
        .m1_adr_i(adr[1]), .m1_dat_i(dat[1]), .m1_dat_o(dat_o[1]), .m1_sel_i(sel[1]), .m1_cti_i(cti[1]),
        .m1_we_i(we[1]), .m1_cyc_i(cyc[1]), .m1_stb_i(stb[1]), .m1_ack_o(ack_o[1]), .m1_err_o(err_o[1]),
        .m2_adr_i(adr[2]), .m2_dat_i(dat[2]), .m2_dat_o(dat_o[2]), .m2_sel_i(sel[2]), .m2_cti_i(cti[2]),
        .m2_we_i(we[2]), .m2_cyc_i(cyc[2]), .m2_stb_i(stb[2]), .m2_ack_o(ack_o[2]), .m2_err_o(err_o[2]),
        .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_sel_o(s_sel_o), .s_cti_o(s_cti_o), .s_we_o(s_we_o),
        .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_dat_i(s_dat_i), .s_ack_i(s_ack_i), .s_err_i(s_err),
        .grant_o(grant_o), .timeout_o(timeout_o)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // winner is the first requester strictly after the previous winner, cyclically
    function automatic int rr(input int prev, input logic [2:0] req);
        for (int i = 1; i <= 3; i++)
            if (req[(prev + i) % 3]) return (prev + i) % 3;
        return -1;
    endfunction

    function automatic logic [31:0] oh(input int w);
        return 32'(1) << w;
    endfunction

    task automatic tick;
        @(posedge sys_clk);
        #1;
    endtask

    task automatic settle;
        #2;
    endtask

    task automatic req(input int i, input logic v);
        cyc[i] = v;
        stb[i] = v;
    endtask

    task automatic drop_all;
        for (int i = 0; i < 3; i++) req(i, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_time_limit: got expired expected finish");
        $fatal(1);
    end

    initial begin
        int w, stall, kind, last_k;
        logic [2:0] rq;
        sys_rst_n = 1'b0;
        ack_mode = 1'b0;
        ack_drv = 1'b0;
        s_err = 1'b0;
        s_dat_i = 32'd0;
        for (int i = 0; i < 3; i++) begin
            adr[i] = 32'h1000_0000 * (i + 1);
            dat[i] = 32'd0;
            sel[i] = 4'hf;
            cti[i] = 3'd0;
            we[i]  = 1'b0;
            req(i, 1'b0);
        end
        #2;
        chk("rst_grant", 32'(grant_o), 0);
        chk("rst_cyc", 32'(s_cyc_o), 0);
        chk("rst_stb", 32'(s_stb_o), 0);
        chk("rst_timeout", 32'(timeout_o), 0);
        chk("rst_ack", 32'(ack_o), 0);
        chk("rst_err", 32'(err_o), 0);
        tick;
        tick;
        sys_rst_n = 1'b1;

        // simultaneous requests, always-ack slave, each master re-requests after its ack
        ack_mode = 1'b1;
        tick;
        for (int i = 0; i < 3; i++) req(i, 1'b1);
        settle;
        chk("rr_idle0", 32'(grant_o), 0);
        for (int k = 0; k < 4; k++) begin
            w = rr(last_m, 3'b111);
            last_m = w;
            tick;
            settle;
            chk("rr_grant", 32'(grant_o), oh(w));
            chk("rr_ack", 32'(ack_o), oh(w));
            chk("rr_adr", s_adr_o, adr[w]);
            tick;
            req(w, 1'b0);
            settle;
            chk("rr_hold", 32'(grant_o), oh(w));
            chk("rr_cyc_drop", 32'(s_cyc_o), 0);
            tick;
            if (k < 3) req(w, 1'b1);
            else drop_all;
            settle;
            chk("rr_gap", 32'(grant_o), 0);
            chk("rr_gap_cyc", 32'(s_cyc_o), 0);
        end
        tick;
        settle;
        chk("rr_end_idle", 32'(grant_o), 0);

        // m1 four-beat burst while m0 waits
        tick;
        req(1, 1'b1);
        we[1] = 1'b0;
        last_m = 1;
        for (int b = 0; b < 4; b++) begin
            tick;
            if (b == 0) req(0, 1'b1);
            adr[1] = 32'h2000_0100 + 32'(4 * b);
            cti[1] = b == 3 ? 3'b111 : 3'b010;
            settle;
            chk("burst_grant", 32'(grant_o), 32'b010);
            chk("burst_adr", s_adr_o, adr[1]);
            chk("burst_cti", 32'(s_cti_o), 32'(cti[1]));
            chk("burst_ack", 32'(ack_o), 32'b010);
        end
        tick;
        req(1, 1'b0);
        settle;
        chk("burst_hold", 32'(grant_o), 32'b010);
        tick;
        settle;
        chk("burst_gap", 32'(grant_o), 0);
        w = rr(last_m, 3'b001);
        last_m = w;
        tick;
        settle;
        chk("burst_next", 32'(grant_o), oh(w));
        chk("burst_next_ack", 32'(ack_o), oh(w));
        tick;
        drop_all;
        tick;
        settle;
        chk("burst_end", 32'(grant_o), 0);

        // watchdog abort on m2 read with a silent slave
        ack_mode = 1'b0;
        tick;
        adr[2] = 32'h6000_0010;
        we[2] = 1'b0;
        req(2, 1'b1);
        last_m = 2;
        for (int k = 0; k < 8; k++) begin
            tick;
            settle;
            chk("wd_stb", 32'(s_stb_o), 1);
            chk("wd_err_early", 32'(err_o), 0);
            chk("wd_to_early", 32'(timeout_o), 0);
        end
        chk("wd_adr", s_adr_o, 32'h6000_0010);
        tick;
        settle;
        chk("wd_err", 32'(err_o), 32'b100);
        chk("wd_timeout", 32'(timeout_o), 1);
        chk("wd_cyc_gate", 32'(s_cyc_o), 0);
        chk("wd_stb_gate", 32'(s_stb_o), 0);
        tick;
        settle;
        chk("wd_err_once", 32'(err_o), 0);
        chk("wd_to_once", 32'(timeout_o), 0);
        chk("wd_still_gated", 32'(s_cyc_o), 0);
        tick;
        tick;
        ack_drv = 1'b1;
        settle;
        chk("wd_late_ack", 32'(ack_o), 0);
        chk("wd_late_err", 32'(err_o), 0);
        tick;
        ack_drv = 1'b0;
        req(2, 1'b0);
        settle;
        chk("wd_abort_hold", 32'(grant_o), 32'b100);
        tick;
        req(0, 1'b1);
        settle;
        chk("wd_idle", 32'(grant_o), 0);
        w = rr(last_m, 3'b001);
        last_m = w;
        tick;
        ack_drv = 1'b1;
        settle;
        chk("wd_after_grant", 32'(grant_o), oh(w));
        chk("wd_after_ack", 32'(ack_o), oh(w));
        tick;
        ack_drv = 1'b0;
        drop_all;
        tick;
        settle;
        chk("wd_after_end", 32'(grant_o), 0);

        // slave error on an m1 write
        tick;
        adr[1] = 32'h3000_0040;
        dat[1] = 32'hDEAD_BEEF;
        sel[1] = 4'b1111;
        we[1] = 1'b1;
        req(1, 1'b1);
        w = rr(last_m, 3'b010);
        last_m = w;
        tick;
        settle;
        chk("serr_grant", 32'(grant_o), oh(w));
        chk("serr_dat", s_dat_o, 32'hDEAD_BEEF);
        chk("serr_sel", 32'(s_sel_o), 32'hf);
        chk("serr_we", 32'(s_we_o), 1);
        tick;
        s_err = 1'b1;
        settle;
        chk("serr_err", 32'(err_o), 32'b010);
        chk("serr_ack", 32'(ack_o), 0);
        chk("serr_dat_hold", s_dat_o, 32'hDEAD_BEEF);
        tick;
        s_err = 1'b0;
        drop_all;
        tick;
        settle;
        chk("serr_end", 32'(grant_o), 0);

        // randomized request sets, payloads, stall lengths and response kinds
        for (int it = 0; it < 40; it++) begin
            rq = 3'($urandom_range(1, 7));
            for (int i = 0; i < 3; i++) begin
                adr[i] = $urandom;
                dat[i] = $urandom;
                sel[i] = 4'($urandom);
                cti[i] = 3'($urandom);
                we[i]  = 1'($urandom);
            end
            w = rr(last_m, rq);
            last_m = w;
            stall = $urandom_range(0, 10);
            kind = $urandom_range(0, 2);
            tick;
            for (int i = 0; i < 3; i++) req(i, rq[i]);
            settle;
            chk("rnd_idle", 32'(grant_o), 0);
            last_k = stall;
            for (int k = 0; k <= last_k; k++) begin
                tick;
                ack_drv = k == stall && kind != 1;
                s_err = k == stall && kind != 0;
                s_dat_i = $urandom;
                settle;
                if (k == 0) begin
                    chk("rnd_grant", 32'(grant_o), oh(w));
                    chk("rnd_adr", s_adr_o, adr[w]);
                    chk("rnd_dat", s_dat_o, dat[w]);
                    chk("rnd_sel", 32'(s_sel_o), 32'(sel[w]));
                    chk("rnd_cti", 32'(s_cti_o), 32'(cti[w]));
                    chk("rnd_we", 32'(s_we_o), 32'(we[w]));
                end
                chk("rnd_ack", 32'(ack_o), k == stall && stall < 8 && kind != 1 ? oh(w) : 0);
                chk("rnd_err", 32'(err_o),
                    (k == stall && stall < 8 && kind != 0) || (stall >= 8 && k == 8) ? oh(w) : 0);
                chk("rnd_timeout", 32'(timeout_o), 32'(stall >= 8 && k == 8));
                chk("rnd_rdat", dat_o[w], s_dat_i);
            end
            tick;
            ack_drv = 1'b0;
            s_err = 1'b0;
            drop_all;
            settle;
            chk("rnd_hold", 32'(grant_o), oh(w));
            tick;
            settle;
            chk("rnd_end", 32'(grant_o), 0);
        end

        // asynchronous reset during an m0 write
        tick;
        we[0] = 1'b1;
        req(0, 1'b1);
        tick;
        settle;
        chk("arst_pre_cyc", 32'(s_cyc_o), 1);
        #1;
        sys_rst_n = 1'b0;
        #1;
        chk("arst_cyc", 32'(s_cyc_o), 0);
        chk("arst_stb", 32'(s_stb_o), 0);
        chk("arst_grant", 32'(grant_o), 0);
        chk("arst_ack", 32'(ack_o), 0);
        tick;
        tick;
        sys_rst_n = 1'b1;
        last_m = 2;
        for (int i = 0; i < 3; i++) req(i, 1'b1);
        settle;
        chk("arst_idle", 32'(grant_o), 0);
        w = rr(last_m, 3'b111);
        tick;
        settle;
        chk("arst_first", 32'(grant_o), oh(w));
        tick;
        drop_all;
        tick;
        settle;
        chk("arst_end", 32'(grant_o), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/wb_rr_arbiter.md
# wb_rr_arbiter

Three-master, one-slave Wishbone arbiter that shares a single slave port between the CPU instruction bus, CPU data bus and JTAG master. Grants rotate round-robin. A grant is held for the whole `cyc` of a transaction, so CTI bursts are never split. A per-transaction watchdog aborts a stalled access with `err` so no master can hang the shared slave. It sits between the masters and a slave port of the system interconnect, or in front of a single shared peripheral.

## Interface
- `TIMEOUT`, default 1023: cycles of unacknowledged `stb` before abort. 0 disables the watchdog. Maximum 65535.
- `sys_clk` in 1: system clock.
- `sys_rst_n` in 1: reset, asynchronous assert, active-low.
- `mN_adr_i` in 32 (N=0,1,2): master address.
- `mN_dat_i` in 32: master write data.
- `mN_dat_o` out 32: read data. Equals `s_dat_i` for every N.
- `mN_sel_i` in 4: byte selects.
- `mN_cti_i` in 3: cycle type.
- `mN_we_i` in 1: write enable.
- `mN_cyc_i` in 1: cycle request.
- `mN_stb_i` in 1: strobe.
- `mN_ack_o` out 1: acknowledge. Granted master only.
- `mN_err_o` out 1: error. Slave error or watchdog abort, granted master only.
- `s_adr_o` out 32, `s_dat_o` out 32, `s_sel_o` out 4, `s_cti_o` out 3, `s_we_o` out 1: slave request, muxed from the granted master.
- `s_cyc_o` out 1, `s_stb_o` out 1: slave cycle and strobe.
- `s_dat_i` in 32: slave read data.
- `s_ack_i` in 1: slave acknowledge.
- `s_err_i` in 1: slave error.
- `grant_o` out 3: one-hot registered grant. 000 when idle.
- `timeout_o` out 1: one-cycle pulse on watchdog abort.

## Operation
- States: IDLE, BUSY, ABORT.
- **IDLE**
  - All `s_*` outputs are driven 0. All `ack_o`/`err_o` are 0.
  - If any `mN_cyc_i`=1, pick the first requester after `last` in the order 0→1→2→0.
  - Register `grant_o` to that master, set `last`, go to BUSY.
- **BUSY**
  - `s_*` outputs follow the granted master combinationally.
  - `s_ack_i`/`s_err_i` are routed to the granted master only. All others read 0.
  - Leave to IDLE on the first cycle where the granted master's `cyc_i`=0. `grant_o` clears on the next edge.
  - Requests from other masters are ignored while BUSY.
- **Watchdog** (16-bit counter `wd`)
  - Cleared in IDLE, and on any cycle with `s_ack_i`, `s_err_i` or granted `stb_i`=0.
  - Otherwise increments while in BUSY.
  - When `wd`==TIMEOUT−1 with no ack/err that cycle (TIMEOUT≠0): go to ABORT.
- **ABORT**
  - First cycle: granted `err_o`=1 and `timeout_o`=1, `s_cyc_o`=`s_stb_o`=0.
  - Later cycles: `err_o`=0 and the slave stays gated.
  - Go to IDLE when the granted master's `cyc_i`=0.
  - Late `s_ack_i`/`s_err_i` in ABORT are discarded.
- **Simultaneous ack and err from the slave:** both are forwarded. The watchdog does not fire that cycle.
- **Reset values:** state IDLE, `grant_o`=000, `last`=2 (so m0 wins first), `wd`=0, `timeout_o`=0. All `s_cyc_o`/`s_stb_o`/`ack_o`/`err_o` are 0.
- **Reset mid-transaction:** outputs drop asynchronously. No ack is delivered.

## Timing
- **Grant latency:** `cyc_i` seen at edge t puts `s_cyc_o` high from t+1. Single access with 0-wait slave: `ack_o` is combinational in the cycle `s_ack_i`=1.
- **Re-arbitration gap:** exactly one IDLE cycle between consecutive grants, including back-to-back from the same master.
- **Watchdog:** `err_o` is asserted exactly TIMEOUT cycles after the first unacknowledged `stb` cycle in BUSY.
- **Burst:** grant holds across all beats until `cyc_i` falls, regardless of `cti_i`.

## Test plan
- After reset, m0, m1 and m2 raise `cyc`/`stb` on the same cycle with an always-ack slave, each master dropping `cyc` after its ack and re-requesting → grants issue m0, m1, m2, m0, with one idle cycle between each.
- m1 runs a 4-beat incrementing burst (cti 010…111) while m0 requests → m0 is not granted until m1 drops `cyc`. The slave sees 4 contiguous beats.
- TIMEOUT=8 with a slave that never acks; m2 reads 0x60000010 → `m2_err_o` and `timeout_o` pulse 8 cycles after `s_stb_o` rises, and `s_cyc_o` drops that cycle. A later m0 request is granted normally.
- The slave asserts ack 3 cycles after the watchdog fires → the late ack is not seen on any `mN_ack_o`.
- `sys_rst_n` pulled low mid-write by m0 → `s_cyc_o`, `s_stb_o` and `grant_o` go to 0 without a clock edge. After release, m0 is granted first again.
- Slave returns `s_err_i` on an m1 write of 0xDEADBEEF/sel 1111 → only `m1_err_o`=1. `s_dat_o`=0xDEADBEEF and `s_sel_o`=1111 during the grant.
